// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: machine-external interrupt controller feeding the core's meip_i.
// Latches and masks up to NSRC sources, picks the fixed-priority winner (index 0
// highest) and holds one claim outstanding until software writes the completion.
//
// Optional feature macro: EXT_IRQC_SYNC_EN adds a 2-flop synchronizer per source
// (needed for asynchronous pins); undefined, sources are used as-is.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   irq_src_i[NSRC]       raw interrupt sources
//   irq_ack_i             one-cycle claim pulse from the core
//   meip_o                interrupt request to the core
//   claim_id_o[5]         current claim, 1-based source index, 0 = none
//   reg_we_i/addr/wdata   register write port (word select on addr[3:2])
//   reg_rdata_o[32]       combinational read data for reg_addr_i
module ext_irq_ctrl #(
  parameter int NSRC = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NSRC-1:0] irq_src_i,
  input  logic            irq_ack_i,
  output logic            meip_o,
  output logic [4:0]      claim_id_o,
  input  logic            reg_we_i,
  input  logic [3:0]      reg_addr_i,
  input  logic [31:0]     reg_wdata_i,
  output logic [31:0]     reg_rdata_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } state_t;

  state_t          state_q, state_n;
  logic [4:0]      claim_q, claim_n;
  logic [NSRC-1:0] src_d, src_q;
  logic [NSRC-1:0] pend_q, pend_n;
  logic [NSRC-1:0] enable_q, edge_q;
  logic [NSRC-1:0] pending, cand;
  logic [NSRC-1:0] claim_clr, w1c_clr, win_onehot;
  logic [4:0]      win_id;
  logic            busy;
  logic            wr_pend, wr_en, wr_edge, wr_claim;
  logic            unused_addr_bits;

  // Byte address; only the word select matters.
  assign unused_addr_bits = ^reg_addr_i[1:0];

  assign wr_pend  = reg_we_i && (reg_addr_i[3:2] == 2'd0);
  assign wr_en    = reg_we_i && (reg_addr_i[3:2] == 2'd1);
  assign wr_edge  = reg_we_i && (reg_addr_i[3:2] == 2'd2);
  assign wr_claim = reg_we_i && (reg_addr_i[3:2] == 2'd3);

`ifdef EXT_IRQC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_d = sync2_q;
`else
  assign src_d = irq_src_i;
`endif

  // Level sources are taken from the sampled copy so that meip_o depends on
  // registered state only and a source seen at edge N is pending after edge N.
  assign pending = (pend_q & edge_q) | (src_q & ~edge_q);
  assign cand    = pending & enable_q;
  assign busy    = (state_q == CLAIMED);

  // Lowest set candidate wins; scanning downwards leaves the lowest index last.
  always_comb begin
    win_id     = 5'd0;
    win_onehot = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_id        = 5'(i + 1);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    claim_n   = claim_q;
    claim_clr = '0;
    case (state_q)
      IDLE: begin
        // An ack with no candidate is spurious and leaves everything alone.
        if (irq_ack_i && (|cand)) begin
          state_n   = CLAIMED;
          claim_n   = win_id;
          claim_clr = win_onehot;
        end
      end
      CLAIMED: begin
        // Acks are ignored here, including one arriving with the completion.
        if (wr_claim && (reg_wdata_i == {27'd0, claim_q}) && (claim_q != 5'd0)) begin
          state_n = IDLE;
          claim_n = 5'd0;
        end
      end
      default: begin
        state_n = IDLE;
        claim_n = 5'd0;
      end
    endcase
  end

  assign w1c_clr = wr_pend ? reg_wdata_i[NSRC-1:0] : '0;

  // Clears first, then new edges: a same-cycle set beats W1C or claim.
  // Masking with EDGE keeps level sources from leaving stale sticky bits.
  assign pend_n = ((pend_q & ~(w1c_clr | claim_clr)) | (src_d & ~src_q)) & edge_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      claim_q  <= 5'd0;
      src_q    <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      edge_q   <= '0;
    end else begin
      state_q <= state_n;
      claim_q <= claim_n;
      src_q   <= src_d;
      pend_q  <= pend_n;
      if (wr_en) begin
        enable_q <= reg_wdata_i[NSRC-1:0];
      end
      if (wr_edge) begin
        edge_q <= reg_wdata_i[NSRC-1:0];
      end
    end
  end

  assign meip_o     = (|cand) & ~busy;
  assign claim_id_o = claim_q;

  always_comb begin
    reg_rdata_o = '0;
    case (reg_addr_i[3:2])
      2'd0: reg_rdata_o[NSRC-1:0] = pending;
      2'd1: reg_rdata_o[NSRC-1:0] = enable_q;
      2'd2: reg_rdata_o[NSRC-1:0] = edge_q;
      2'd3: reg_rdata_o[4:0]      = claim_q;
      default: reg_rdata_o = '0;
    endcase
  end

endmodule
